mango_dbus_bridge: RTL and testbench

Data-bus bridge between the MangoMIPS32 core's single-cycle data port (`dbus_en/addr/wen/wdata/rdata`) and an external SRAM-like split-handshake memory port (request/address-accept/data-return). It latches one core access, issues it with a req/addr_ok handshake and waits for data_ok. It holds the core pipeline via `dbus_stall` until the access completes. It sits directly downstream of the MEM stage's data-bus outputs, between the core top and the memory system.

---
 rtl/mango_dbus_bridge.sv | 185 ++++++++++++++++++
 tb/tb_mango_dbus_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mango_dbus_bridge.sv
// Bridges the core's single-cycle data port to a split req/addr_ok/data_ok memory port.
// Latency: request issued the cycle after dbus_en; data returned in DONE, 3-4 cycles per access minimum.
// Backpressure: dbus_stall holds the core until DONE; optional watchdog (MANGO_DBUS_TIMEOUT_EN) aborts hung accesses.
module mango_dbus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,          // active-low, asynchronous assert
    input  logic        dbus_en_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [3:0]  dbus_wen_i,
    input  logic [31:0] dbus_wdata_i,
    output logic [31:0] dbus_rdata_o,
    output logic        dbus_stall_o,
    output logic        m_req_o,
    output logic        m_wr_o,
    output logic [3:0]  m_strb_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_addr_ok_i,
    input  logic        m_data_ok_i,
    input  logic [31:0] m_rdata_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_wr_q, m_wr_d;
    logic [3:0]  m_strb_q, m_strb_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef MANGO_DBUS_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

    logic [7:0]  wdog_q, wdog_d;
    logic        orphan_q, orphan_d;
    logic        bus_err_q, bus_err_d;
    logic        wdog_hit;

    assign wdog_hit  = (wdog_q == WDOG_LIMIT);
    assign bus_err_o = bus_err_q;
`else
    logic        unused_cfg;

    assign unused_cfg = ^8'(TIMEOUT);
    assign bus_err_o  = 1'b0;
`endif

    // Next-state and output-register logic for the access FSM
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_strb_d  = m_strb_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
`ifdef MANGO_DBUS_TIMEOUT_EN
        wdog_d    = wdog_q;
        orphan_d  = orphan_q;
        bus_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef MANGO_DBUS_TIMEOUT_EN
                // An aborted access still owes us a data_ok; swallow it before issuing again.
                if (orphan_q) begin
                    if (m_data_ok_i) begin
                        orphan_d = 1'b0;
                    end
                end else
`endif
                if (dbus_en_i) begin
                    m_addr_d  = dbus_addr_i;
                    m_strb_d  = dbus_wen_i;
                    m_wdata_d = dbus_wdata_i;
                    m_wr_d    = |dbus_wen_i;
                    m_req_d   = 1'b1;
                    state_d   = S_ADDR;
`ifdef MANGO_DBUS_TIMEOUT_EN
                    wdog_d    = '0;
`endif
                end
            end
            S_ADDR: begin
`ifdef MANGO_DBUS_TIMEOUT_EN
                wdog_d = wdog_q + 8'd1;
`endif
                if (m_addr_ok_i && m_data_ok_i) begin
                    m_req_d = 1'b0;
                    rdata_d = m_rdata_i;
                    state_d = S_DONE;
`ifdef MANGO_DBUS_TIMEOUT_EN
                end else if (wdog_hit) begin
                    // If the slave accepts on the abort cycle its data is still outstanding.
                    m_req_d   = 1'b0;
                    rdata_d   = 32'hDEAD_BEEF;
                    bus_err_d = 1'b1;
                    orphan_d  = m_addr_ok_i;
                    state_d   = S_DONE;
`endif
                end else if (m_addr_ok_i) begin
                    m_req_d = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
`ifdef MANGO_DBUS_TIMEOUT_EN
                wdog_d = wdog_q + 8'd1;
`endif
                if (m_data_ok_i) begin
                    rdata_d = m_rdata_i;
                    state_d = S_DONE;
`ifdef MANGO_DBUS_TIMEOUT_EN
                end else if (wdog_hit) begin
                    rdata_d   = 32'hDEAD_BEEF;
                    bus_err_d = 1'b1;
                    orphan_d  = 1'b1;
                    state_d   = S_DONE;
`endif
                end
            end
            S_DONE: begin
`ifdef MANGO_DBUS_TIMEOUT_EN
                // The late response may already arrive while we sit in DONE.
                if (orphan_q && m_data_ok_i) begin
                    orphan_d = 1'b0;
                end
`endif
                state_d = S_IDLE;
            end
        endcase
    end

    // All state and bus-facing outputs are registered here
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_strb_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
`ifdef MANGO_DBUS_TIMEOUT_EN
            wdog_q    <= '0;
            orphan_q  <= 1'b0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_strb_q  <= m_strb_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
`ifdef MANGO_DBUS_TIMEOUT_EN
            wdog_q    <= wdog_d;
            orphan_q  <= orphan_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    // The core is released only in DONE; in reset the FSM reads as IDLE so stall follows en.
    assign dbus_stall_o = dbus_en_i & (state_q != S_DONE);

    assign dbus_rdata_o = rdata_q;
    assign m_req_o      = m_req_q;
    assign m_wr_o       = m_wr_q;
    assign m_strb_o     = m_strb_q;
    assign m_addr_o     = m_addr_q;
    assign m_wdata_o    = m_wdata_q;

endmodule

// File: tb/tb_mango_dbus_bridge.sv
// Directed bench for mango_dbus_bridge: read, delayed write, fused accept, flush, back-to-back, reset, watchdog.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Build with MANGO_DBUS_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=4.
module tb_mango_dbus_bridge;

`ifdef MANGO_DBUS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dbus_en;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_stall;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_strb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mango_dbus_bridge #(.TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .dbus_en_i    (dbus_en),
        .dbus_addr_i  (dbus_addr),
        .dbus_wen_i   (dbus_wen),
        .dbus_wdata_i (dbus_wdata),
        .dbus_rdata_o (dbus_rdata),
        .dbus_stall_o (dbus_stall),
        .m_req_o      (m_req),
        .m_wr_o       (m_wr),
        .m_strb_o     (m_strb),
        .m_addr_o     (m_addr),
        .m_wdata_o    (m_wdata),
        .m_addr_ok_i  (m_addr_ok),
        .m_data_ok_i  (m_data_ok),
        .m_rdata_i    (m_rdata),
        .bus_err_o    (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; dbus_en = 1'b1; dbus_addr = 32'h1; dbus_wen = 4'hF; dbus_wdata = 32'h2;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
        sample();
        n_chk++; if (dbus_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got=%b exp=1", dbus_stall); end
        n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", m_req); end
        n_chk++; if ({m_wr, m_strb, m_addr, m_wdata} !== 69'd0) begin n_fail++; $display("FAIL rst_bus got=%b/%h/%h/%h exp=0", m_wr, m_strb, m_addr, m_wdata); end
        n_chk++; if (dbus_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", dbus_rdata); end
        n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", bus_err); end
        dbus_en = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        dbus_en = 1'b1; dbus_addr = 32'h0000_0100; dbus_wen = 4'h0; dbus_wdata = '0;
        sample();
        n_chk++; if (dbus_stall !== 1'b1 || m_req !== 1'b0) begin n_fail++; $display("FAIL rd_c0 got=stall%b req%b exp=stall1 req0", dbus_stall, m_req); end
        tick(); m_addr_ok = 1'b1;
        sample();
        n_chk++; if (m_req !== 1'b1 || dbus_stall !== 1'b1) begin n_fail++; $display("FAIL rd_c1 got=req%b stall%b exp=req1 stall1", m_req, dbus_stall); end
        n_chk++; if (m_addr !== 32'h0000_0100 || m_wr !== 1'b0) begin n_fail++; $display("FAIL rd_c1_addr got=%h wr%b exp=00000100 wr0", m_addr, m_wr); end
        tick(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
        sample();
        n_chk++; if (m_req !== 1'b0 || dbus_stall !== 1'b1) begin n_fail++; $display("FAIL rd_c2 got=req%b stall%b exp=req0 stall1", m_req, dbus_stall); end
        tick(); m_data_ok = 1'b0; m_rdata = 32'hFFFF_FFFF;
        sample();
        n_chk++; if (dbus_stall !== 1'b0) begin n_fail++; $display("FAIL rd_c3_stall got=%b exp=0", dbus_stall); end
        n_chk++; if (dbus_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_c3_rdata got=%h exp=12345678", dbus_rdata); end
        n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rd_c3_err got=%b exp=0", bus_err); end
        tick(); dbus_en = 1'b0;
        sample();
        n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rd_c4_req got=%b exp=0", m_req); end
    endtask

    task automatic test_idle_data_ok();
        // Stray data_ok in IDLE must not touch the read register
        m_data_ok = 1'b1; m_rdata = 32'h5555_AAAA;
        tick(); m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_rdata !== 32'h1234_5678 || m_req !== 1'b0) begin n_fail++; $display("FAIL idle_dok got=%h req%b exp=12345678 req0", dbus_rdata, m_req); end
        tick();
    endtask

    task automatic test_write_delayed();
        dbus_en = 1'b1; dbus_addr = 32'h8000_0010; dbus_wen = 4'b0011; dbus_wdata = 32'hCAFE_BABE;
        tick();
        // Perturb the core-side bus to prove the request fields are held in registers
        dbus_addr = 32'h0BAD_0BAD; dbus_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_chk++; if (m_req !== 1'b1 || m_wr !== 1'b1 || m_strb !== 4'b0011 || m_addr !== 32'h8000_0010 || m_wdata !== 32'hCAFE_BABE)
                begin n_fail++; $display("FAIL wr_hold%0d got=req%b wr%b strb%b addr%h wdata%h exp=req1 wr1 strb0011 addr80000010 wdataCAFEBABE", i, m_req, m_wr, m_strb, m_addr, m_wdata); end
            tick();
        end
        m_addr_ok = 1'b1;
        sample();
        n_chk++; if (m_req !== 1'b1 || dbus_stall !== 1'b1) begin n_fail++; $display("FAIL wr_acc got=req%b stall%b exp=req1 stall1", m_req, dbus_stall); end
        tick(); m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_00AA;
        sample();
        n_chk++; if (m_req !== 1'b0 || dbus_stall !== 1'b1) begin n_fail++; $display("FAIL wr_data got=req%b stall%b exp=req0 stall1", m_req, dbus_stall); end
        tick(); m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_stall !== 1'b0) begin n_fail++; $display("FAIL wr_done_stall got=%b exp=0", dbus_stall); end
        tick(); dbus_en = 1'b0;
    endtask

    task automatic test_fused_accept();
        dbus_en = 1'b1; dbus_addr = 32'h0000_2000; dbus_wen = 4'h0;
        tick(); m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hA5A5_0F0F;
        sample();
        n_chk++; if (m_req !== 1'b1 || dbus_stall !== 1'b1) begin n_fail++; $display("FAIL fz_c1 got=req%b stall%b exp=req1 stall1", m_req, dbus_stall); end
        tick(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_stall !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL fz_c2 got=stall%b req%b exp=stall0 req0", dbus_stall, m_req); end
        n_chk++; if (dbus_rdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL fz_rdata got=%h exp=A5A50F0F", dbus_rdata); end
        tick(); dbus_en = 1'b0;
    endtask

    task automatic test_flush();
        dbus_en = 1'b1; dbus_addr = 32'h0000_3000; dbus_wen = 4'h0;
        tick(); m_addr_ok = 1'b1;
        tick(); m_addr_ok = 1'b0; dbus_en = 1'b0;
        sample();
        n_chk++; if (dbus_stall !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL fl_data got=stall%b req%b exp=stall0 req0", dbus_stall, m_req); end
        tick(); m_data_ok = 1'b1; m_rdata = 32'h0BAD_F00D;
        tick(); m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL fl_rdata got=%h exp=0BADF00D", dbus_rdata); end
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fl_noreq%0d got=%b exp=0", i, m_req); end
        end
    endtask

    task automatic test_back_to_back();
        dbus_en = 1'b1; dbus_addr = 32'h0000_4000; dbus_wen = 4'h0;
        tick(); m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1111_0001;
        tick(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_stall !== 1'b0 || dbus_rdata !== 32'h1111_0001) begin n_fail++; $display("FAIL b2b_done1 got=stall%b rdata%h exp=stall0 rdata11110001", dbus_stall, dbus_rdata); end
        tick(); dbus_addr = 32'h0000_4004;
        sample();
        n_chk++; if (dbus_stall !== 1'b1 || m_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=stall%b req%b exp=stall1 req0", dbus_stall, m_req); end
        tick(); m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h2222_0002;
        sample();
        n_chk++; if (m_req !== 1'b1 || m_addr !== 32'h0000_4004) begin n_fail++; $display("FAIL b2b_req2 got=req%b addr%h exp=req1 addr00004004", m_req, m_addr); end
        tick(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_stall !== 1'b0 || dbus_rdata !== 32'h2222_0002) begin n_fail++; $display("FAIL b2b_done2 got=stall%b rdata%h exp=stall0 rdata22220002", dbus_stall, dbus_rdata); end
        tick(); dbus_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        dbus_en = 1'b1; dbus_addr = 32'h0000_5000; dbus_wen = 4'h0;
        tick();
        #1;
        n_chk++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL rm_pre got=%b exp=1", m_req); end
        rst = 1'b0;
        #1;
        n_chk++; if (m_req !== 1'b0 || dbus_stall !== 1'b1) begin n_fail++; $display("FAIL rm_async got=req%b stall%b exp=req0 stall1", m_req, dbus_stall); end
        n_chk++; if (dbus_rdata !== 32'h0 || m_addr !== 32'h0) begin n_fail++; $display("FAIL rm_regs got=rdata%h addr%h exp=0 0", dbus_rdata, m_addr); end
        dbus_en = 1'b0;
        sample();
        rst = 1'b1;
        tick(); m_data_ok = 1'b1; m_rdata = 32'h7777_7777;
        tick(); m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_rdata !== 32'h0 || m_req !== 1'b0) begin n_fail++; $display("FAIL rm_late got=rdata%h req%b exp=0 req0", dbus_rdata, m_req); end
        tick();
    endtask

`ifdef MANGO_DBUS_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        dbus_en = 1'b1; dbus_addr = 32'h0000_6000; dbus_wen = 4'h0;
        tick(); m_addr_ok = 1'b1;
        tick(); m_addr_ok = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (bus_err === 1'b1) seen = 1'b1;
            else tick();
        end
        n_chk++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", seen); end
        n_chk++; if (dbus_rdata !== 32'hDEAD_BEEF || dbus_stall !== 1'b0) begin n_fail++; $display("FAIL to_done got=rdata%h stall%b exp=DEADBEEF stall0", dbus_rdata, dbus_stall); end
        tick(); dbus_addr = 32'h0000_6004;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_chk++; if (dbus_stall !== 1'b1 || m_req !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL to_block%0d got=stall%b req%b err%b exp=stall1 req0 err0", i, dbus_stall, m_req, bus_err); end
            tick();
        end
        m_data_ok = 1'b1; m_rdata = 32'h1111_1111;
        tick(); m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_discard got=%h exp=DEADBEEF", dbus_rdata); end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (m_req === 1'b1) seen = 1'b1;
            else begin tick(); sample(); end
        end
        n_chk++; if (seen !== 1'b1 || m_addr !== 32'h0000_6004) begin n_fail++; $display("FAIL to_reissue got=req%b addr%h exp=req1 addr00006004", seen, m_addr); end
        tick(); m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h2222_3333;
        sample();
        tick(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_rdata !== 32'h2222_3333 || dbus_stall !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL to_second got=rdata%h stall%b err%b exp=22223333 stall0 err0", dbus_rdata, dbus_stall, bus_err); end
        tick(); dbus_en = 1'b0;
    endtask
`else
    task automatic test_timeout();
        // Without the watchdog a silent slave simply keeps the core stalled.
        dbus_en = 1'b1; dbus_addr = 32'h0000_6000; dbus_wen = 4'h0;
        tick(); m_addr_ok = 1'b1;
        tick(); m_addr_ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            n_chk++; if (dbus_stall !== 1'b1 || bus_err !== 1'b0) begin n_fail++; $display("FAIL nowd%0d got=stall%b err%b exp=stall1 err0", i, dbus_stall, bus_err); end
            tick();
        end
        m_data_ok = 1'b1; m_rdata = 32'h3333_4444;
        tick(); m_data_ok = 1'b0;
        sample();
        n_chk++; if (dbus_stall !== 1'b0 || dbus_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL nowd_done got=stall%b rdata%h exp=stall0 33334444", dbus_stall, dbus_rdata); end
        tick(); dbus_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_idle_data_ok();
        test_write_delayed();
        test_fused_accept();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
